bnn_layer_sequencer: RTL

Control FSM for the binary-NN PE array. It takes a layer job of word count and tile count over a start/done handshake and sequences the array clock-enable, accumulate and weight-SRAM addressing. It hands each finished tile of NUM_PES outputs to the writeback path and exports `fsm_state`, `ce_array`, `accumulate`, `compute_count` and `pe_active` in the encoding the performance monitor consumes.

---
 rtl/bnn_pkg.sv | 16 +
 rtl/bnn_active_mask.sv | 26 ++
 rtl/bnn_layer_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and constants for the binary-NN layer sequencer and its
// performance monitor (fsm_state_e encoding is consumed externally).
package bnn_pkg;

  localparam int unsigned NUM_PES_DEF = 64;
  localparam int unsigned MAX_WORDS   = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_COMPUTE   = 3'd2,
    ST_DONE      = 3'd3,
    ST_WRITEBACK = 3'd4
  } fsm_state_e;

endpackage

// File: rtl/bnn_active_mask.sv
// bnn_active_mask: combinational per-PE activity mask; narrows the final tile to
// last_tile_pes lanes (0 or >= NUM_PES means the full tile).
module bnn_active_mask #(
  parameter int unsigned NUM_PES = 64,
  parameter int unsigned CNT_W   = $clog2(NUM_PES + 1)
) (
  input  logic               ce,
  input  logic               last_tile,
  input  logic [CNT_W-1:0]   last_tile_pes,
  output logic [NUM_PES-1:0] pe_active
);

  always_comb begin
    pe_active = '0;
    if (ce) begin
      if (!last_tile || (last_tile_pes == '0) || (last_tile_pes >= CNT_W'(NUM_PES))) begin
        pe_active = '1;
      end else begin
        for (int unsigned i = 0; i < NUM_PES; i++) begin
          pe_active[i] = (i < 32'(last_tile_pes));
        end
      end
    end
  end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: start/done job FSM driving PE-array enable, accumulate and
// weight-SRAM addressing, tile by tile. Optional macro: BNN_SEQ_PARTIAL_TILE_EN.
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter int unsigned NUM_PES   = NUM_PES_DEF,
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [6:0]                   num_words,
  input  logic [ADDR_W-1:0]            num_tiles,
`ifdef BNN_SEQ_PARTIAL_TILE_EN
  input  logic [$clog2(NUM_PES+1)-1:0] last_tile_pes,
`endif
  input  logic                         stall,
  input  logic                         wb_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [2:0]                   fsm_state,
  output logic                         ce_array,
  output logic                         accumulate,
  output logic [6:0]                   compute_count,
  output logic [ADDR_W-1:0]            wt_addr,
  output logic [NUM_PES-1:0]           pe_active,
  output logic                         wb_valid
);

  if (WORD_SIZE == 0) begin : g_bad_word_size
    $error("WORD_SIZE must be non-zero");
  end

  fsm_state_e        state_q, state_d;
  logic [6:0]        words_q, words_d;
  logic [ADDR_W-1:0] tiles_q, tiles_d;
  logic [ADDR_W-1:0] tile_idx_q, tile_idx_d;
  logic [6:0]        compute_count_q, compute_count_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic              err_q, err_d;
  logic              issue;

  always_comb begin
    state_d         = state_q;
    words_d         = words_q;
    tiles_d         = tiles_q;
    tile_idx_d      = tile_idx_q;
    compute_count_d = compute_count_q;
    wt_addr_d       = wt_addr_q;
    err_d           = 1'b0;
    issue           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((num_words == '0) || (num_words > 7'(MAX_WORDS)) || (num_tiles == '0)) begin
            err_d = 1'b1;
          end else begin
            words_d = num_words;
            tiles_d = num_tiles;
            state_d = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        compute_count_d = '0;
        tile_idx_d      = '0;
        wt_addr_d       = '0;
        state_d         = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (!stall) begin
          issue     = 1'b1;
          wt_addr_d = wt_addr_q + ADDR_W'(1);
          if (compute_count_q == words_q - 7'd1) begin
            state_d = ST_WRITEBACK;
          end else begin
            compute_count_d = compute_count_q + 7'd1;
          end
        end
      end
      ST_WRITEBACK: begin
        if (wb_ready) begin
          if (tile_idx_q == tiles_q - ADDR_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            tile_idx_d      = tile_idx_q + ADDR_W'(1);
            compute_count_d = '0;
            state_d         = ST_COMPUTE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      words_q         <= '0;
      tiles_q         <= '0;
      tile_idx_q      <= '0;
      compute_count_q <= '0;
      wt_addr_q       <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      words_q         <= words_d;
      tiles_q         <= tiles_d;
      tile_idx_q      <= tile_idx_d;
      compute_count_q <= compute_count_d;
      wt_addr_q       <= wt_addr_d;
      err_q           <= err_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;
  assign fsm_state     = state_q;
  assign ce_array      = issue;
  assign accumulate    = issue && (compute_count_q != '0);
  assign compute_count = compute_count_q;
  assign wt_addr       = wt_addr_q;
  assign wb_valid      = (state_q == ST_WRITEBACK);

`ifdef BNN_SEQ_PARTIAL_TILE_EN
  localparam int unsigned CNT_W = $clog2(NUM_PES + 1);

  logic [CNT_W-1:0] ltp_q, ltp_d;

  always_comb begin
    ltp_d = ltp_q;
    if ((state_q == ST_IDLE) && (state_d == ST_INIT)) ltp_d = last_tile_pes;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ltp_q <= '0;
    else       ltp_q <= ltp_d;
  end

  bnn_active_mask #(
    .NUM_PES (NUM_PES),
    .CNT_W   (CNT_W)
  ) u_active_mask (
    .ce            (issue),
    .last_tile     (tile_idx_q == tiles_q - ADDR_W'(1)),
    .last_tile_pes (ltp_q),
    .pe_active     (pe_active)
  );
`else
  assign pe_active = {NUM_PES{issue}};
`endif

endmodule
